// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a simple valid/ready command port into single APB
// transfers (SETUP -> ACCESS -> RESP) and reports completion on a one-cycle
// response pulse. All outputs are registered and updated on PCLK rising edges.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that waits
// TIMEOUT_CYC cycles with PREADY low; the abort completes with rsp_err=1.
// Without the macro the bridge waits for PREADY indefinitely.
module apb_master_bridge #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB master side
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

`ifdef APB_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYC itself.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  // TIMEOUT_CYC only matters when the timeout is compiled in; this empty
  // block keeps the parameter referenced in the default build.
  if (TIMEOUT_CYC < 0) begin : g_timeout_unused
  end
`endif

  // Transfer sequencer: state and every output register advance together.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            // Latch the command straight into the APB address/data registers.
            state     <= SETUP;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end

        ACCESS: begin
          if (PREADY) begin
            state     <= RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? {DATA_W{1'b0}} : PRDATA;
            rsp_err   <= PSLVERR;
          end else begin
`ifdef APB_TIMEOUT_EN
            // This cycle is the TIMEOUT_CYC-th wait cycle: give up.
            if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              state     <= RESP;
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              wait_cnt  <= wait_cnt + CNT_W'(1);
            end
`else
            state <= ACCESS;
`endif
          end
        end

        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge. Expected responses are pushed to
// a scoreboard queue when a command is accepted and popped when rsp_valid fires.
module tb_apb_master_bridge;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 16;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  typedef struct packed {
    logic [7:0] addr;
    logic       write;
    logic [7:0] wdata;
  } xfer_t;

  rsp_t  rsp_q[$];
  xfer_t xfer_q[$];

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // Present a command, wait (bounded) for acceptance, optionally push the
  // expected response. Returns one cycle after the accepting edge (SETUP).
  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rdata, input logic exp_err,
                          input bit push);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 20) begin tick; n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait: cmd_ready=%0b required 1", cmd_ready);
    end
    tick;
    cmd_valid = 1'b0;
    if (push) rsp_q.push_back('{rdata: exp_rdata, err: exp_err});
  endtask

  task automatic test_reset;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 8'h00; PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) tick;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== 29'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err});
    end
    PRESET = 1'b0;
    tick;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait;
    rsp_t exp;
    PREADY = 1'b1; PRDATA = 8'hEE;
    send_cmd(1'b1, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1);
    // N+1: SETUP
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 8'h00, 8'h10}) begin
      failures++;
      $display("FAIL wr_setup: sel=%0b en=%0b wr=%0b addr=%h wdata=%h required 1 0 1 00 10",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick; // N+2: ACCESS
    checks++;
    if ({PSEL, PENABLE, PADDR, PWDATA, rsp_valid} !== {1'b1, 1'b1, 8'h00, 8'h10, 1'b0}) begin
      failures++;
      $display("FAIL wr_access: sel=%0b en=%0b addr=%h wdata=%h rv=%0b required 1 1 00 10 0",
               PSEL, PENABLE, PADDR, PWDATA, rsp_valid);
    end
    tick; // N+3: response
    checks++;
    if (rsp_valid !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp_valid: rv=%0b sel=%0b en=%0b required 1 0 0", rsp_valid, PSEL, PENABLE);
    end else if (rsp_q.size() == 0) begin
      failures++; $display("FAIL wr_rsp_unexpected: queue empty");
    end else begin
      exp = rsp_q.pop_front();
      checks++;
      if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
        failures++;
        $display("FAIL wr_rsp_data: rdata=%h err=%0b required %h %0b", rsp_rdata, rsp_err, exp.rdata, exp.err);
      end
    end
    tick; // N+4
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_n4: rv=%0b ready=%0b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait;
    rsp_t exp;
    bit   bad = 1'b0;
    PREADY = 1'b0; PRDATA = 8'hAA;
    send_cmd(1'b0, 8'h01, 8'h77, 8'hFF, 1'b0, 1'b1);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b0, 8'h01, 8'h00}) begin
      failures++;
      $display("FAIL rd_setup: sel=%0b en=%0b wr=%0b addr=%h wdata=%h required 1 0 0 01 00",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick;
    // Four ACCESS cycles; PREADY rises during the fourth.
    for (int i = 0; i < 4; i++) begin
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 8'h01 || rsp_valid !== 1'b0) bad = 1'b1;
      if (i == 3) begin PREADY = 1'b1; PRDATA = 8'hFF; end
      tick;
    end
    PREADY = 1'b0; PRDATA = 8'h55;
    checks++;
    if (bad) begin
      failures++; $display("FAIL rd_access_hold: access phase unstable or early rsp, required 4 stable cycles");
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL rd_rsp_valid: rv=%0b required 1", rsp_valid);
    end else if (rsp_q.size() != 0) begin
      exp = rsp_q.pop_front();
      checks++;
      if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
        failures++;
        $display("FAIL rd_rsp_data: rdata=%h err=%0b required %h %0b", rsp_rdata, rsp_err, exp.rdata, exp.err);
      end
    end
    tick;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hFF) begin
      failures++;
      $display("FAIL rd_hold: rv=%0b rdata=%h required 0 ff", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_slverr;
    rsp_t exp;
    int   n = 0;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 8'h3C;
    send_cmd(1'b0, 8'h02, 8'h00, 8'h3C, 1'b1, 1'b1);
    while (!rsp_valid && n < 10) begin tick; n++; end
    PSLVERR = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL err_rsp_valid: rv=%0b required 1", rsp_valid);
    end else if (rsp_q.size() != 0) begin
      exp = rsp_q.pop_front();
      checks++;
      if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
        failures++;
        $display("FAIL err_rsp_data: rdata=%h err=%0b required %h %0b", rsp_rdata, rsp_err, exp.rdata, exp.err);
      end
    end
    tick;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL err_pulse: rv=%0b err=%0b required 0 1", rsp_valid, rsp_err);
    end
  endtask

  task automatic test_timeout;
    rsp_t exp;
    int   cnt = 0;
    int   n   = 0;
    PREADY = 1'b0; PRDATA = 8'h77;
    send_cmd(1'b0, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1);
`ifdef APB_TIMEOUT_EN
    while (!rsp_valid && n < 40) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1) cnt++;
      tick; n++;
    end
    checks++;
    if (cnt != TIMEOUT_CYC) begin
      failures++; $display("FAIL to_cycles: access cycles=%0d required %0d", cnt, TIMEOUT_CYC);
    end
`else
    // Without the timeout the bridge must keep waiting; release PREADY late.
    rsp_q.delete();
    rsp_q.push_back('{rdata: 8'h66, err: 1'b0});
    while (n < 20) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1 && rsp_valid === 1'b0) cnt++;
      tick; n++;
    end
    checks++;
    if (cnt != 19) begin
      failures++; $display("FAIL wait_forever: access cycles=%0d required 19", cnt);
    end
    PREADY = 1'b1; PRDATA = 8'h66;
    tick;
    PREADY = 1'b0;
`endif
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL to_rsp_valid: rv=%0b required 1", rsp_valid);
    end else if (rsp_q.size() != 0) begin
      exp = rsp_q.pop_front();
      checks++;
      if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
        failures++;
        $display("FAIL to_rsp_data: rdata=%h err=%0b required %h %0b", rsp_rdata, rsp_err, exp.rdata, exp.err);
      end
    end
    // Next command completes normally.
    PREADY = 1'b1;
    send_cmd(1'b1, 8'h04, 8'h22, 8'h00, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 10) begin tick; n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL to_next_valid: rv=%0b required 1", rsp_valid);
    end else if (rsp_q.size() != 0) begin
      exp = rsp_q.pop_front();
      checks++;
      if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
        failures++;
        $display("FAIL to_next_data: rdata=%h err=%0b required %h %0b", rsp_rdata, rsp_err, exp.rdata, exp.err);
      end
    end
    tick;
  endtask

  task automatic test_reset_mid;
    bit saw_rsp = 1'b0;
    PREADY = 1'b0;
    send_cmd(1'b1, 8'h05, 8'h99, 8'h00, 1'b0, 1'b0);
    tick;
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      failures++; $display("FAIL rst_mid_access: sel=%0b en=%0b required 1 1", PSEL, PENABLE);
    end
    PRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== 29'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %h required 0",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err});
    end
    PREADY = 1'b1;
    tick;
    PRESET = 1'b0;
    tick;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) saw_rsp = 1'b1;
      tick;
    end
    checks++;
    if (saw_rsp) begin
      failures++; $display("FAIL rst_mid_no_rsp: response or transfer after reset, required none");
    end
  endtask

  task automatic test_back_to_back;
    xfer_t cmds[3];
    xfer_t ex;
    rsp_t  exp;
    int    acc = 0, setups = 0, rsps = 0, cyc = 0, last_acc = 0;
    logic  was_ready;
    cmds[0] = '{addr: 8'h10, write: 1'b1, wdata: 8'hA1};
    cmds[1] = '{addr: 8'h11, write: 1'b0, wdata: 8'h00};
    cmds[2] = '{addr: 8'h12, write: 1'b1, wdata: 8'hC3};
    PREADY = 1'b1; PRDATA = 8'h5A; PSLVERR = 1'b0;
    cmd_valid = 1'b1; cmd_write = cmds[0].write; cmd_addr = cmds[0].addr; cmd_wdata = 8'hA1;
    while (rsps < 3 && cyc < 60) begin
      was_ready = cmd_ready;
      tick; cyc++;
      if (was_ready && cmd_valid) begin
        xfer_q.push_back(cmds[acc]);
        rsp_q.push_back('{rdata: cmds[acc].write ? 8'h00 : 8'h5A, err: 1'b0});
        if (acc > 0) begin
          checks++;
          if (cyc - last_acc != 4) begin
            failures++; $display("FAIL b2b_spacing: %0d cycles required 4", cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc++;
        if (acc == 3) cmd_valid = 1'b0;
        else begin
          cmd_write = cmds[acc].write; cmd_addr = cmds[acc].addr; cmd_wdata = cmds[acc].wdata;
        end
      end
      if (PSEL === 1'b1 && PENABLE === 1'b0) begin
        setups++;
        checks++;
        if (xfer_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_xfer: addr=%h required none", PADDR);
        end else begin
          ex = xfer_q.pop_front();
          if (PADDR !== ex.addr || PWRITE !== ex.write || PWDATA !== ex.wdata) begin
            failures++;
            $display("FAIL b2b_xfer: addr=%h wr=%0b wdata=%h required %h %0b %h",
                     PADDR, PWRITE, PWDATA, ex.addr, ex.write, ex.wdata);
          end
        end
      end
      if (rsp_valid === 1'b1) begin
        rsps++;
        checks++;
        if (rsp_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_rsp: rdata=%h required none", rsp_rdata);
        end else begin
          exp = rsp_q.pop_front();
          if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
            failures++;
            $display("FAIL b2b_rsp: rdata=%h err=%0b required %h %0b", rsp_rdata, rsp_err, exp.rdata, exp.err);
          end
        end
      end
    end
    cmd_valid = 1'b0;
    repeat (6) begin
      tick;
      if (PSEL === 1'b1 && PENABLE === 1'b0) setups++;
    end
    checks++;
    if (acc != 3 || setups != 3 || rsps != 3) begin
      failures++;
      $display("FAIL b2b_counts: accepts=%0d xfers=%0d rsps=%0d required 3 3 3", acc, setups, rsps);
    end
  endtask

  initial begin
    test_reset;
    test_write_zero_wait;
    test_read_wait;
    test_slverr;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
